decodificador_gray: RTL and testbench

// - Receiving end of the 4-bit coding link: captures code word S3..S0 when the encoder raises ready,

---
 rtl/decodificador_gray_pkg.sv | 16 +
 rtl/decodificador_gray_if.sv | 32 +++
 rtl/decodificador_gray_sync_edge_detect.sv | 28 ++
 rtl/decodificador_gray.sv | 88 ++++++++
 tb/tb_decodificador_gray.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/decodificador_gray_pkg.sv
// Shared definitions for the 4-bit reflected-Gray coding link.
// The Gray encoder is also the golden model for the matching encoder and its benches.
package codificador_pkg;

   localparam int CODE_W = 4;

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   function automatic logic [CODE_W-1:0] gray_enc(input logic [CODE_W-1:0] n);
      return n ^ (n >> 1);
   endfunction

endpackage

// File: rtl/decodificador_gray_if.sv
// Link-side bundle: encoder code word and strobe in, decoded word and status out.
// The master modport is the encoder or bench side; the slave modport is the decoder side.
interface decodificador_gray_if #(
   parameter int CNT_W = 4
);
   import codificador_pkg::*;

   logic             i_s3;
   logic             i_s2;
   logic             i_s1;
   logic             i_s0;
   logic             i_ready;
   logic             o_a;
   logic             o_b;
   logic             o_c;
   logic             o_d;
   logic             o_valid;
   logic             o_busy;
   logic             o_overrun;
   logic [CNT_W-1:0] o_count;

   modport master (
      output i_s3, i_s2, i_s1, i_s0, i_ready,
      input  o_a, o_b, o_c, o_d, o_valid, o_busy, o_overrun, o_count
   );

   modport slave (
      input  i_s3, i_s2, i_s1, i_s0, i_ready,
      output o_a, o_b, o_c, o_d, o_valid, o_busy, o_overrun, o_count
   );

endinterface

// File: rtl/decodificador_gray_sync_edge_detect.sv
// Brings the unclocked ready strobe into the clk domain and flags its rising edge.
// rise is a one-cycle pulse while the synchronized level is newly high.
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_async,
   output logic o_rise
);
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   w_sync_out;

   assign w_sync_out = r_sync[SYNC_STAGES-1];
   assign o_rise     = w_sync_out & ~r_prev;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_prev <= w_sync_out;
      end
   end

endmodule

// File: rtl/decodificador_gray.sv
// Receiving end of the Gray link: captures S3..S0 on a synchronized ready rise and
// decodes it one bit per cycle into A..D, then pulses valid for one cycle.
//
// state | meaning
// IDLE  | waiting for a ready rise; captures the code word when one arrives
// SHIFT | decoding, one output bit per cycle, idx 0..3 (MSB first)
module decodificador_gray #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   decodificador_gray_if.slave  bus
);
   import codificador_pkg::*;

   state_t              r_state;
   logic [CODE_W-1:0]   r_code;
   logic [CODE_W-1:0]   r_work;
   logic [1:0]          r_idx;
   logic [CODE_W-1:0]   r_abcd;
   logic                r_valid;
   logic                r_overrun;
   logic [CNT_W-1:0]    r_count;
   logic                w_rise;
   logic                w_bit;

   sync_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .reset   (reset),
      .i_async (bus.i_ready),
      .o_rise  (w_rise)
   );

   // Work reg is cleared at capture, so its LSB is 0 for the first (MSB) bit.
   assign w_bit = r_work[0] ^ r_code[~r_idx];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_code    <= '0;
         r_work    <= '0;
         r_idx     <= '0;
         r_abcd    <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
         r_count   <= '0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_rise) begin
                  r_code  <= {bus.i_s3, bus.i_s2, bus.i_s1, bus.i_s0};
                  r_work  <= '0;
                  r_idx   <= '0;
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               if (w_rise) begin
                  r_overrun <= 1'b1;
               end
               r_work <= {r_work[CODE_W-2:0], w_bit};
               r_idx  <= r_idx + 2'd1;
               if (r_idx == 2'd3) begin
                  r_abcd  <= {r_work[CODE_W-2:0], w_bit};
                  r_valid <= 1'b1;
                  r_count <= r_count + 1'b1;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.o_a       = r_abcd[3];
   assign bus.o_b       = r_abcd[2];
   assign bus.o_c       = r_abcd[1];
   assign bus.o_d       = r_abcd[0];
   assign bus.o_valid   = r_valid;
   assign bus.o_busy    = (r_state != IDLE);
   assign bus.o_overrun = r_overrun;
   assign bus.o_count   = r_count;

endmodule

// File: tb/tb_decodificador_gray.sv
// Scoreboard bench for decodificador_gray: stimulus pushes expected words,
// a negedge monitor pops and compares on every valid pulse.
module tb_decodificador_gray;
   import codificador_pkg::*;

   typedef struct {
      logic [3:0] abcd;
      logic [3:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   decodificador_gray_if #(.CNT_W(4)) bus ();

   decodificador_gray #(
      .SYNC_STAGES (2),
      .CNT_W       (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   exp_t       q[$];
   int         checks  = 0;
   int         errors  = 0;
   int         n_valid = 0;
   int         n_push  = 0;
   logic [3:0] exp_cnt = 4'd0;
   logic       prev_valid = 1'b0;

   // gray codes for n = 0..15
   logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [3:0] abcd);
      exp_t e;
      exp_cnt = exp_cnt + 4'd1;
      e.abcd  = abcd;
      e.cnt   = exp_cnt;
      q.push_back(e);
      n_push++;
   endtask

   task automatic set_s(input logic [3:0] s);
      {bus.i_s3, bus.i_s2, bus.i_s1, bus.i_s0} = s;
   endtask

   task automatic send(input logic [3:0] s, input logic [3:0] exp_abcd);
      @(negedge clk);
      set_s(s);
      bus.i_ready = 1'b1;
      push_exp(exp_abcd);
      repeat (8) @(negedge clk);
      bus.i_ready = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      reset = 1'b0;
      repeat (cycles) @(negedge clk);
      reset   = 1'b1;
      exp_cnt = 4'd0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (reset === 1'b1 && bus.o_valid === 1'b1) begin
         n_valid++;
         chk("valid_width", {31'd0, prev_valid}, 32'd0);
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got ABCD=%b, expected no output",
                     {bus.o_a, bus.o_b, bus.o_c, bus.o_d});
         end else begin
            e = q.pop_front();
            chk("abcd",  {28'd0, bus.o_a, bus.o_b, bus.o_c, bus.o_d}, {28'd0, e.abcd});
            chk("count", {28'd0, bus.o_count}, {28'd0, e.cnt});
         end
      end
      prev_valid = bus.o_valid;
   end

   initial begin
      reset       = 1'b0;
      bus.i_ready = 1'b0;
      set_s(4'h0);

      // reset held with ready toggling
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.i_ready = ~bus.i_ready;
      end
      chk("rst_abcd",    {28'd0, bus.o_a, bus.o_b, bus.o_c, bus.o_d}, 32'd0);
      chk("rst_valid",   {31'd0, bus.o_valid}, 32'd0);
      chk("rst_busy",    {31'd0, bus.o_busy}, 32'd0);
      chk("rst_count",   {28'd0, bus.o_count}, 32'd0);
      chk("rst_overrun", {31'd0, bus.o_overrun}, 32'd0);
      bus.i_ready = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);

      // single word 0111 -> 0101, with busy observed after capture
      set_s(4'b0111);
      bus.i_ready = 1'b1;
      push_exp(4'b0101);
      repeat (3) @(negedge clk);
      chk("busy_after_capture", {31'd0, bus.o_busy}, 32'd1);
      repeat (5) @(negedge clk);
      chk("busy_after_done", {31'd0, bus.o_busy}, 32'd0);
      bus.i_ready = 1'b0;
      repeat (4) @(negedge clk);

      // sweep all 16 codes from a fresh counter
      do_reset(2);
      repeat (2) @(negedge clk);
      for (int n = 0; n < 16; n++) begin
         send(gray_tab[n], n[3:0]);
      end
      chk("count_wrap",    {28'd0, bus.o_count}, 32'd0);
      chk("sweep_overrun", {31'd0, bus.o_overrun}, 32'd0);

      // overrun: second rise arrives while the first word is still decoding
      @(negedge clk);
      set_s(4'b0001);
      bus.i_ready = 1'b1;
      push_exp(4'b0001);
      repeat (2) @(negedge clk);
      bus.i_ready = 1'b0;
      repeat (2) @(negedge clk);
      set_s(4'b0011);
      bus.i_ready = 1'b1;
      repeat (10) @(negedge clk);
      bus.i_ready = 1'b0;
      repeat (4) @(negedge clk);
      chk("overrun_set", {31'd0, bus.o_overrun}, 32'd1);
      send(4'b0110, 4'b0100);
      chk("overrun_sticky", {31'd0, bus.o_overrun}, 32'd1);

      // reset during the second SHIFT cycle aborts the word
      @(negedge clk);
      set_s(4'b1000);
      bus.i_ready = 1'b1;
      repeat (4) @(negedge clk);
      reset       = 1'b0;
      bus.i_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_abcd",    {28'd0, bus.o_a, bus.o_b, bus.o_c, bus.o_d}, 32'd0);
      chk("abort_count",   {28'd0, bus.o_count}, 32'd0);
      chk("abort_overrun", {31'd0, bus.o_overrun}, 32'd0);
      chk("abort_valid",   {31'd0, bus.o_valid}, 32'd0);
      reset   = 1'b1;
      exp_cnt = 4'd0;
      repeat (2) @(negedge clk);
      send(4'b0010, 4'b0011);

      // ready held high, S changes after capture
      @(negedge clk);
      set_s(4'b1101);
      bus.i_ready = 1'b1;
      push_exp(4'b1001);
      repeat (4) @(negedge clk);
      set_s(4'b0000);
      repeat (16) @(negedge clk);
      bus.i_ready = 1'b0;
      repeat (6) @(negedge clk);

      chk("queue_empty", q.size(), 32'd0);
      chk("valid_total", n_valid, n_push);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
